// File: rtl/ppu_pkg.sv
// ppu_pkg: shared FSM state type, word geometry and strobe helpers for the
// PPU output packer.
package ppu_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned GLB_WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PACK,
        ST_DRAIN,
        ST_DONE
    } pk_state_t;

    // Byte enables for a word whose highest filled lane is `lane`.
    function automatic logic [BYTES_PER_WORD-1:0] lane_strb(input logic [1:0] lane);
        logic [BYTES_PER_WORD-1:0] s;
        case (lane)
            2'd0:    s = 4'b0001;
            2'd1:    s = 4'b0011;
            2'd2:    s = 4'b0111;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [GLB_WORD_W-1:0] strb_to_mask(input logic [BYTES_PER_WORD-1:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage

// File: rtl/ppu_packer_fifo.sv
// packer_fifo: synchronous first-word-fall-through FIFO between the byte
// packer and the GLB write port.
module packer_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_last
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra pointer bit separates full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_fill;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_fill  = r_wr_ptr - r_rd_ptr;
    assign o_empty = (w_fill == '0);
    assign o_full  = (w_fill == (AW+1)'(DEPTH));
    assign o_last  = (w_fill == (AW+1)'(1));
    assign w_rd_en = i_pop && !o_empty;
    assign w_wr_en = i_push && (!o_full || w_rd_en);
    assign o_data  = r_mem[r_wr_ptr[AW-1:0] - r_wr_ptr[AW-1:0] + r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ppu_packer.sv
// ppu_packer: packs the PPU byte stream into 32-bit GLB words at consecutive
// addresses. Define PPU_PACKER_WSTRB_EN to add the glb_wstrb byte-enable port.
module ppu_packer
    import ppu_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [15:0]           cfg_len,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  glb_req,
    input  logic                  glb_gnt,
    output logic [ADDR_W-1:0]     glb_addr,
    output logic [GLB_WORD_W-1:0] glb_wdata,
`ifdef PPU_PACKER_WSTRB_EN
    output logic [BYTES_PER_WORD-1:0] glb_wstrb,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int unsigned FIFO_W = ADDR_W + BYTES_PER_WORD + GLB_WORD_W;

    pk_state_t                 r_state;
    pk_state_t                 w_state_next;
    logic [15:0]               r_len;
    logic [15:0]               r_byte_cnt;
    logic [ADDR_W-1:0]         r_addr;
    logic [GLB_WORD_W-1:0]     r_word;
    logic [GLB_WORD_W-1:0]     w_word_next;
    logic                      r_overflow;
    logic [1:0]                w_lane;
    logic                      w_accept;
    logic                      w_last_byte;
    logic                      w_word_ready;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_fifo_last;
    logic [FIFO_W-1:0]         w_fifo_din;
    logic [FIFO_W-1:0]         w_fifo_dout;
    logic [ADDR_W-1:0]         w_head_addr;
    logic [BYTES_PER_WORD-1:0] w_head_strb;
    logic [GLB_WORD_W-1:0]     w_head_data;

    assign w_lane       = r_byte_cnt[1:0];
    assign w_accept     = (r_state == ST_PACK) && in_valid;
    assign w_last_byte  = (r_byte_cnt == r_len - 16'd1);
    assign w_word_ready = w_accept && ((w_lane == 2'd3) || w_last_byte);
    assign w_pop        = glb_req && glb_gnt;
    assign w_push       = w_word_ready && (!w_fifo_full || w_pop);
    assign w_drop       = w_word_ready && w_fifo_full && !w_pop;

    // The word register is never cleared; stale upper lanes of a partial
    // final word are removed by the strobe mask on the output side.
    always_comb begin
        w_word_next = r_word;
        w_word_next[{w_lane, 3'b000} +: 8] = in_data;
    end

    assign w_fifo_din = {r_addr, lane_strb(w_lane), w_word_next};

    packer_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_data (w_fifo_din),
        .o_data (w_fifo_dout),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty),
        .o_last (w_fifo_last)
    );

    assign {w_head_addr, w_head_strb, w_head_data} = w_fifo_dout;

    assign glb_req   = !w_fifo_empty;
    assign glb_addr  = glb_req ? w_head_addr : '0;
    assign glb_wdata = glb_req ? (w_head_data & strb_to_mask(w_head_strb)) : '0;
`ifdef PPU_PACKER_WSTRB_EN
    assign glb_wstrb = glb_req ? w_head_strb : '0;
`endif
    assign busy      = (r_state == ST_PACK) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign overflow  = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // DRAIN exits on the edge that grants the last word, so done follows it directly.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_start) w_state_next = ST_PACK;
            ST_PACK:  if (w_word_ready && w_last_byte) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty || (w_pop && w_fifo_last)) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && cfg_start) begin
                r_len      <= (cfg_len == '0) ? 16'd1 : cfg_len;
                r_byte_cnt <= '0;
                r_addr     <= cfg_base_addr;
                r_overflow <= 1'b0;
            end
            if (w_accept) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
                r_word     <= w_word_next;
            end
            // Dropped words still consume an address.
            if (w_word_ready) r_addr <= r_addr + ADDR_W'(1);
            if (w_drop)       r_overflow <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (glb_req && !glb_gnt) |=> (glb_req && $stable(glb_addr) && $stable(glb_wdata)));

endmodule
